riscv_fetchctrl: RTL and testbench
==================================

# riscv_fetchctrl

Fetch-stage sequencer for the RV64IMC core. It owns the fetch PC and drives a single-outstanding request/grant/response port into instruction memory. It holds each returned parcel in a one-entry output slot until decode consumes it, and steps the PC by 2 or 4 according to the RVC encoding. Redirects from execute discard in-flight and buffered fetches. The block sits between the imem port and the F/D pipeline register, ahead of the compressed decoder.

## Interface
- `width`, 64, address/PC width.
- `RESET_PC`, `{width{1'b0}}`, first fetch address after reset.
- `i_riscv_fetchctrl_clk`  in  1  core clock; all state changes on its rising edge.
- `i_riscv_fetchctrl_rst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_riscv_fetchctrl_stall`  in  1  decode cannot accept; slot is held.
- `i_riscv_fetchctrl_redirect`  in  1  taken branch/jump (pcsrc).
- `i_riscv_fetchctrl_target`  in  width  redirect address; bit 0 is forced to 0.
- `o_riscv_fetchctrl_req`  out  1  imem request.
- `o_riscv_fetchctrl_addr`  out  width  halfword-aligned fetch address; imem returns the 32 bits starting there.
- `i_riscv_fetchctrl_gnt`  in  1  imem accepts request this cycle.
- `i_riscv_fetchctrl_rvalid`  in  1  response valid; cannot be back-pressured.
- `i_riscv_fetchctrl_rdata`  in  32  response parcel.
- `o_riscv_fetchctrl_valid`  out  1  slot holds a live instruction.
- `o_riscv_fetchctrl_inst`  out  32  slot instruction, raw and not yet RVC-expanded.
- `o_riscv_fetchctrl_pc`  out  width  PC of slot instruction.

## Operation
- Registers: `state`, `fetch_pc`, slot (`valid`, `inst`, `pc`).
- Reset values: `state`=IDLE, `fetch_pc`=RESET_PC, `o_valid`=0, `o_inst`=32'h0000_0013, `o_pc`=RESET_PC, `o_req`=0, `o_addr`=RESET_PC.
- `o_addr` always equals `fetch_pc`.
- `o_req` is combinational: 1 in REQ; 1 in HOLD when `!stall && !redirect`; otherwise 0.
- Consume = `o_valid && !stall`. On consume with no refill, `valid` clears next cycle.
- IDLE: go to REQ.
- REQ: on `gnt`, go to WAIT. Without `gnt`, stay in REQ. The address may change while the request is ungranted.
- WAIT: on `rvalid`, load the slot with `inst`=rdata, `pc`=fetch_pc, `valid`=1. Set `fetch_pc += (rdata[1:0]==2'b11) ? 4 : 2` and go to HOLD.
- HOLD: the slot is full.
  - Consume with `gnt`: go to WAIT.
  - Consume without `gnt`: go to REQ.
  - No consume: stay in HOLD.
- FLUSH: a stale response is pending. On `rvalid`, drop the data and go to REQ. No request is issued in FLUSH.
- Redirect has priority over every other event in every state:
  - `fetch_pc` ← {target[width-1:1],1'b0}.
  - Slot `valid` ← 0.
  - `stall` is ignored for that cycle.
- Redirect next state:
  - IDLE, REQ (no gnt) or HOLD → REQ.
  - REQ with gnt same cycle → FLUSH.
  - WAIT without rvalid → FLUSH.
  - WAIT with rvalid same cycle → REQ, and rdata is discarded.
  - FLUSH → FLUSH, with the target updated.
- Arithmetic: the PC increment wraps modulo 2^width, so 0xFFFF_FFFF_FFFF_FFFE + 2 = 0.
- Invariant: at most one request is outstanding, and a response never arrives while the slot is full.
- Async reset asserted mid-operation forces all registers to reset values immediately. Any imem response that follows is the memory's responsibility; imem is reset on the same net.

## Timing
- Memory with same-cycle `gnt` and 1-cycle `rvalid`, no stall: one instruction every 2 cycles. Sequence is REQ/HOLD(req) → WAIT → HOLD(req).
- First request: cycle 1 after reset deassertion (IDLE takes cycle 0).
- Response-to-valid latency: `o_valid` rises the cycle after `rvalid`.
- Redirect-to-request latency:
  - From REQ, HOLD or IDLE: the new address is on `o_addr` the next cycle.
  - From WAIT or FLUSH: the new address is requested in the cycle after the stale `rvalid`.

## Structure
- Shared package `riscv_pkg` holds:
  - `riscv_fetchctrl_state_e` (IDLE, REQ, WAIT, HOLD, FLUSH).
  - `RISCV_NOP` = 32'h0000_0013.
  - Localparams `RISCV_ILEN_C` = 2 and `RISCV_ILEN_I` = 4.
- Reuse existing `riscv_pcadder` for the `fetch_pc` increment.
- Otherwise flat: one FSM always_ff/always_comb pair.

## Test plan
- Reset release, `gnt`=1, `rvalid` 1 cycle later, rdata 0x00500093 then 0x4505 then 0x00000013: `o_addr` goes 0x0, 0x4, 0x6. `o_pc`/`o_inst` match, with `o_valid` high every 2nd cycle.
- Stall held 3 cycles with the slot full: `o_req`=0, slot unchanged. Request at 0x4 is issued in the cycle `stall` drops.
- Redirect to 0x1001 in WAIT, `rvalid` 2 cycles later with 0xDEADBEEF: the data is dropped and `o_valid` stays 0. Next `o_addr`=0x1000.
- Redirect coincident with `rvalid` in WAIT: next cycle `o_req`=1, `o_addr`=target, `o_valid`=0.
- `fetch_pc`=0xFFFF_FFFF_FFFF_FFFE with a compressed parcel: next `o_addr`=0x0.
- Async reset pulsed low in HOLD mid-clock: outputs return to reset values before the next edge. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core package: fetch FSM states, NOP encoding, instruction
// lengths and a helper that classifies a 16-bit parcel as compressed or not.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } riscv_fetchctrl_state_e;

    localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

    localparam int unsigned RISCV_ILEN_C = 2;
    localparam int unsigned RISCV_ILEN_I = 4;

    // Width of the length operand handed to the PC adder.
    localparam int unsigned RISCV_ILEN_W = 3;

    // A parcel is a full 32-bit instruction only when its two LSBs are 2'b11.
    function automatic logic riscv_is_rvc(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/riscv_pcadder.sv
// PC incrementer: sum = pc + len, wrapping modulo 2^width.
// Ports:
//   pc   in  width         current PC
//   len  in  RISCV_ILEN_W  instruction length in bytes (2 or 4)
//   sum  out width         next sequential PC
module riscv_pcadder
    import riscv_pkg::*;
#(
    parameter int unsigned width = 64
) (
    input  logic [width-1:0]        pc,
    input  logic [RISCV_ILEN_W-1:0] len,
    output logic [width-1:0]        sum
);

    assign sum = pc + width'(len);

endmodule

// File: rtl/riscv_fetchctrl.sv
// Fetch-stage sequencer. Owns the fetch PC, issues one outstanding imem
// request at a time, parks each returned parcel in a one-entry slot until
// decode consumes it, and steps the PC by 2 or 4 according to the RVC
// encoding. A redirect discards in-flight and buffered fetches.
// Ports:
//   i_riscv_fetchctrl_clk/rst       clock, async active-low reset
//   i_riscv_fetchctrl_stall         decode cannot accept the slot
//   i_riscv_fetchctrl_redirect/target  taken branch/jump and its address
//   o_riscv_fetchctrl_req/addr      imem request and halfword-aligned address
//   i_riscv_fetchctrl_gnt           imem accepts the request
//   i_riscv_fetchctrl_rvalid/rdata  imem response (not back-pressurable)
//   o_riscv_fetchctrl_valid/inst/pc slot contents presented to decode
module riscv_fetchctrl
    import riscv_pkg::*;
#(
    parameter int unsigned      width    = 64,
    parameter logic [width-1:0] RESET_PC = {width{1'b0}}
) (
    input  logic             i_riscv_fetchctrl_clk,
    input  logic             i_riscv_fetchctrl_rst,
    input  logic             i_riscv_fetchctrl_stall,
    input  logic             i_riscv_fetchctrl_redirect,
    input  logic [width-1:0] i_riscv_fetchctrl_target,
    output logic             o_riscv_fetchctrl_req,
    output logic [width-1:0] o_riscv_fetchctrl_addr,
    input  logic             i_riscv_fetchctrl_gnt,
    input  logic             i_riscv_fetchctrl_rvalid,
    input  logic [31:0]      i_riscv_fetchctrl_rdata,
    output logic             o_riscv_fetchctrl_valid,
    output logic [31:0]      o_riscv_fetchctrl_inst,
    output logic [width-1:0] o_riscv_fetchctrl_pc
);

    riscv_fetchctrl_state_e state_q, state_d;
    logic [width-1:0]       fetch_pc_q, fetch_pc_d;
    logic                   valid_q, valid_d;
    logic [31:0]            inst_q, inst_d;
    logic [width-1:0]       pc_q, pc_d;

    logic                    consume;
    logic [width-1:0]        target_aligned;
    logic [RISCV_ILEN_W-1:0] ilen;
    logic [width-1:0]        pc_inc;

    assign consume = valid_q && !i_riscv_fetchctrl_stall;

    // Branch targets are halfword aligned; bit 0 is simply masked off.
    assign target_aligned = i_riscv_fetchctrl_target & ~width'(1);

    // Length of the parcel arriving from imem this cycle.
    assign ilen = riscv_is_rvc(i_riscv_fetchctrl_rdata[1:0])
                ? RISCV_ILEN_W'(RISCV_ILEN_C)
                : RISCV_ILEN_W'(RISCV_ILEN_I);

    riscv_pcadder #(
        .width (width)
    ) u_pcadder (
        .pc  (fetch_pc_q),
        .len (ilen),
        .sum (pc_inc)
    );

    // Outputs straight from registers, except the request strobe.
    assign o_riscv_fetchctrl_addr  = fetch_pc_q;
    assign o_riscv_fetchctrl_valid = valid_q;
    assign o_riscv_fetchctrl_inst  = inst_q;
    assign o_riscv_fetchctrl_pc    = pc_q;

    // In HOLD the next fetch overlaps the consume, so only request when the
    // slot is actually draining and no redirect is about to move the PC.
    always_comb begin
        o_riscv_fetchctrl_req = 1'b0;
        if (state_q == REQ) begin
            o_riscv_fetchctrl_req = 1'b1;
        end else if (state_q == HOLD) begin
            o_riscv_fetchctrl_req = !i_riscv_fetchctrl_stall && !i_riscv_fetchctrl_redirect;
        end
    end

    // Next-state and slot update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        valid_d    = valid_q && !consume;
        inst_d     = inst_q;
        pc_d       = pc_q;

        if (i_riscv_fetchctrl_redirect) begin
            // Redirect wins everywhere; stall is irrelevant since the slot empties.
            fetch_pc_d = target_aligned;
            valid_d    = 1'b0;
            unique case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = i_riscv_fetchctrl_gnt ? FLUSH : REQ;
                WAIT:    state_d = i_riscv_fetchctrl_rvalid ? REQ : FLUSH;
                HOLD:    state_d = REQ;
                FLUSH:   state_d = FLUSH;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (i_riscv_fetchctrl_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (i_riscv_fetchctrl_rvalid) begin
                        valid_d    = 1'b1;
                        inst_d     = i_riscv_fetchctrl_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = pc_inc;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        state_d = i_riscv_fetchctrl_gnt ? WAIT : REQ;
                    end
                end
                // Stale response from before a redirect: swallow it.
                FLUSH: begin
                    if (i_riscv_fetchctrl_rvalid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and slot registers.
    always_ff @(posedge i_riscv_fetchctrl_clk or negedge i_riscv_fetchctrl_rst) begin
        if (!i_riscv_fetchctrl_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            inst_q     <= RISCV_NOP;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_riscv_fetchctrl.sv
// Directed bench for riscv_fetchctrl: a per-cycle vector table driving the
// imem handshake, stall and redirect, plus a hand-written async reset sequence.
module tb_riscv_fetchctrl;

    localparam int unsigned W     = 64;
    localparam int unsigned NVEC  = 31;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          redirect;
    logic [W-1:0]  target;
    logic          req;
    logic [W-1:0]  addr;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          valid;
    logic [31:0]   inst;
    logic [W-1:0]  pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_fetchctrl #(
        .width    (W),
        .RESET_PC ({W{1'b0}})
    ) dut (
        .i_riscv_fetchctrl_clk      (clk),
        .i_riscv_fetchctrl_rst      (rst_n),
        .i_riscv_fetchctrl_stall    (stall),
        .i_riscv_fetchctrl_redirect (redirect),
        .i_riscv_fetchctrl_target   (target),
        .o_riscv_fetchctrl_req      (req),
        .o_riscv_fetchctrl_addr     (addr),
        .i_riscv_fetchctrl_gnt      (gnt),
        .i_riscv_fetchctrl_rvalid   (rvalid),
        .i_riscv_fetchctrl_rdata    (rdata),
        .o_riscv_fetchctrl_valid    (valid),
        .o_riscv_fetchctrl_inst     (inst),
        .o_riscv_fetchctrl_pc       (pc)
    );

    typedef struct {
        logic          stall;
        logic          redirect;
        logic [W-1:0]  target;
        logic          gnt;
        logic          rvalid;
        logic [31:0]   rdata;
        logic          req;
        logic [W-1:0]  addr;
        logic          valid;
        logic          chk;     // also compare inst/pc
        logic [31:0]   inst;
        logic [W-1:0]  pc;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic r, input logic [W-1:0] t,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic eq, input logic [W-1:0] ea, input logic ev,
                                input logic c, input logic [31:0] ei, input logic [W-1:0] ep);
        vec_t v;
        v.stall = s; v.redirect = r; v.target = t; v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.req = eq; v.addr = ea; v.valid = ev; v.chk = c; v.inst = ei; v.pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %h, want %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Cycle 0 is IDLE right after reset release; each row is one cycle.
        vecs[0]  = mk(0,0,64'h0,   0,0,32'h0,        0,64'h0,   0,1,32'h0000_0013,64'h0);
        vecs[1]  = mk(0,0,64'h0,   1,0,32'h0,        1,64'h0,   0,0,32'h0,64'h0);
        vecs[2]  = mk(0,0,64'h0,   0,1,32'h0050_0093,0,64'h0,   0,0,32'h0,64'h0);
        // Slot full, decode stalled 3 cycles: no request.
        vecs[3]  = mk(1,0,64'h0,   0,0,32'h0,        0,64'h4,   1,1,32'h0050_0093,64'h0);
        vecs[4]  = mk(1,0,64'h0,   0,0,32'h0,        0,64'h4,   1,1,32'h0050_0093,64'h0);
        vecs[5]  = mk(1,0,64'h0,   0,0,32'h0,        0,64'h4,   1,1,32'h0050_0093,64'h0);
        vecs[6]  = mk(0,0,64'h0,   1,0,32'h0,        1,64'h4,   1,1,32'h0050_0093,64'h0);
        vecs[7]  = mk(0,0,64'h0,   0,1,32'h0000_4505,0,64'h4,   0,0,32'h0,64'h0);
        vecs[8]  = mk(0,0,64'h0,   1,0,32'h0,        1,64'h6,   1,1,32'h0000_4505,64'h4);
        vecs[9]  = mk(0,0,64'h0,   0,1,32'h0000_0013,0,64'h6,   0,0,32'h0,64'h0);
        vecs[10] = mk(0,0,64'h0,   1,0,32'h0,        1,64'hA,   1,1,32'h0000_0013,64'h6);
        // Redirect in WAIT; stale response two cycles later is dropped.
        vecs[11] = mk(0,1,64'h1001,0,0,32'h0,        0,64'hA,   0,0,32'h0,64'h0);
        vecs[12] = mk(0,0,64'h0,   0,0,32'h0,        0,64'h1000,0,0,32'h0,64'h0);
        vecs[13] = mk(0,0,64'h0,   0,1,32'hDEAD_BEEF,0,64'h1000,0,0,32'h0,64'h0);
        vecs[14] = mk(0,0,64'h0,   1,0,32'h0,        1,64'h1000,0,0,32'h0,64'h0);
        // Redirect coincident with rvalid in WAIT.
        vecs[15] = mk(0,1,64'h2002,0,1,32'h0000_0013,0,64'h1000,0,0,32'h0,64'h0);
        vecs[16] = mk(0,0,64'h0,   0,0,32'h0,        1,64'h2002,0,0,32'h0,64'h0);
        // Redirect in REQ without gnt, then with gnt (goes to FLUSH).
        vecs[17] = mk(0,1,64'h3000,0,0,32'h0,        1,64'h2002,0,0,32'h0,64'h0);
        vecs[18] = mk(0,1,64'h4000,1,0,32'h0,        1,64'h3000,0,0,32'h0,64'h0);
        vecs[19] = mk(0,0,64'h0,   0,1,32'h0BAD_F00D,0,64'h4000,0,0,32'h0,64'h0);
        vecs[20] = mk(0,0,64'h0,   1,0,32'h0,        1,64'h4000,0,0,32'h0,64'h0);
        vecs[21] = mk(0,0,64'h0,   0,1,32'h0000_8082,0,64'h4000,0,0,32'h0,64'h0);
        // Redirect in HOLD while stalled: no request, slot dropped.
        vecs[22] = mk(1,1,64'h5000,0,0,32'h0,        0,64'h4002,1,1,32'h0000_8082,64'h4000);
        // PC wrap: odd target is aligned, compressed parcel steps to 0.
        vecs[23] = mk(0,1,64'hFFFF_FFFF_FFFF_FFFF,0,0,32'h0,1,64'h5000,0,0,32'h0,64'h0);
        vecs[24] = mk(0,0,64'h0,   1,0,32'h0,        1,64'hFFFF_FFFF_FFFF_FFFE,0,0,32'h0,64'h0);
        vecs[25] = mk(0,0,64'h0,   0,1,32'h0000_0001,0,64'hFFFF_FFFF_FFFF_FFFE,0,0,32'h0,64'h0);
        // Consume without gnt falls back to REQ.
        vecs[26] = mk(0,0,64'h0,   0,0,32'h0,        1,64'h0,   1,1,32'h0000_0001,64'hFFFF_FFFF_FFFF_FFFE);
        vecs[27] = mk(0,0,64'h0,   1,0,32'h0,        1,64'h0,   0,0,32'h0,64'h0);
        vecs[28] = mk(0,0,64'h0,   0,0,32'h0,        0,64'h0,   0,0,32'h0,64'h0);
        vecs[29] = mk(0,0,64'h0,   0,1,32'h00A0_0113,0,64'h0,   0,0,32'h0,64'h0);
        vecs[30] = mk(1,0,64'h0,   0,0,32'h0,        0,64'h4,   1,1,32'h00A0_0113,64'h0);

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; target = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            stall    = vecs[i].stall;
            redirect = vecs[i].redirect;
            target   = vecs[i].target;
            gnt      = vecs[i].gnt;
            rvalid   = vecs[i].rvalid;
            rdata    = vecs[i].rdata;
            #1;
            check("req",   i, 64'(req),   64'(vecs[i].req));
            check("addr",  i, addr,       vecs[i].addr);
            check("valid", i, 64'(valid), 64'(vecs[i].valid));
            if (vecs[i].chk) begin
                check("inst", i, 64'(inst), 64'(vecs[i].inst));
                check("pc",   i, pc,        vecs[i].pc);
            end
            @(posedge clk);
            #1;
        end

        // Still in HOLD (stalled); pulse async reset mid-cycle.
        stall = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        #1;
        check("hold_valid", 100, 64'(valid), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 101, 64'(valid), 64'h0);
        check("rst_inst",  101, 64'(inst),  64'h0000_0013);
        check("rst_pc",    101, pc,         64'h0);
        check("rst_addr",  101, addr,       64'h0);
        check("rst_req",   101, 64'(req),   64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("idle_req",  102, 64'(req),   64'h0);
        @(posedge clk);
        #2;
        check("restart_req",  103, 64'(req), 64'h1);
        check("restart_addr", 103, addr,     64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
